// File: rtl/dm_access_ctrl_if.sv
// CPU-side request/response channel of the data-memory access controller.
// The master drives requests; the slave (controller) accepts and completes them.
interface dm_access_ctrl_if #(
   parameter int unsigned data_size    = 32,
   parameter int unsigned address_size = 15
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_write;
   logic [1:0]              req_size;
   logic                    req_unsigned;
   logic [address_size+1:0] req_addr;
   logic [data_size-1:0]    req_wdata;
   logic                    resp_valid;
   logic                    resp_err;
   logic [data_size-1:0]    resp_rdata;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata
   );
endinterface

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns byte/halfword/word loads and stores into
// word-wide DM commands, using read-modify-write for sub-word stores.
module dm_access_ctrl #(
   parameter int unsigned data_size    = 32,
   parameter int unsigned address_size = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   dm_access_ctrl_if.slave         bus,
   output logic                    DM_enable,
   output logic                    DM_read,
   output logic                    DM_write,
   output logic [address_size-1:0] DM_address,
   output logic [data_size-1:0]    DM_in,
   input  logic [data_size-1:0]    DM_out
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t               state;
   logic                 wr_l;
   logic [1:0]           size_l;
   logic                 uns_l;
   logic [1:0]           lane_l;
   logic [data_size-1:0] wdata_l;
   logic [data_size-1:0] word_q;
   logic                 req_err;

   function automatic logic [data_size-1:0] extract(input logic [data_size-1:0] w,
                                                    input logic [1:0] sz, input logic uns,
                                                    input logic [1:0] a);
      logic [data_size-1:0] sh;
      logic [data_size-1:0] r;
      r = w;
      if (sz == 2'b00) begin
         sh = w >> {a, 3'b000};
         r  = uns ? {{(data_size-8){1'b0}}, sh[7:0]} : {{(data_size-8){sh[7]}}, sh[7:0]};
      end else if (sz == 2'b01) begin
         sh = w >> {a[1], 4'b0000};
         r  = uns ? {{(data_size-16){1'b0}}, sh[15:0]} : {{(data_size-16){sh[15]}}, sh[15:0]};
      end
      return r;
   endfunction

   // Word stores ignore the captured word and pass the store data through.
   function automatic logic [data_size-1:0] merge(input logic [data_size-1:0] w,
                                                  input logic [1:0] sz, input logic [1:0] a,
                                                  input logic [data_size-1:0] d);
      logic [data_size-1:0] mask;
      logic [data_size-1:0] lane;
      logic [data_size-1:0] r;
      r = d;
      if (sz == 2'b00) begin
         mask = {{(data_size-8){1'b0}}, 8'hff} << {a, 3'b000};
         lane = {{(data_size-8){1'b0}}, d[7:0]} << {a, 3'b000};
         r    = (w & ~mask) | lane;
      end else if (sz == 2'b01) begin
         mask = {{(data_size-16){1'b0}}, 16'hffff} << {a[1], 4'b0000};
         lane = {{(data_size-16){1'b0}}, d[15:0]} << {a[1], 4'b0000};
         r    = (w & ~mask) | lane;
      end
      return r;
   endfunction

   assign req_err = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));

   assign bus.req_ready = (state == IDLE) && !rst;
   assign DM_in = ((state == WR) && !rst) ? merge(word_q, size_l, lane_l, wdata_l) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         wr_l           <= 1'b0;
         size_l         <= 2'b00;
         uns_l          <= 1'b0;
         lane_l         <= 2'b00;
         wdata_l        <= '0;
         word_q         <= '0;
         DM_enable      <= 1'b0;
         DM_read        <= 1'b0;
         DM_write       <= 1'b0;
         DM_address     <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_err   <= 1'b0;
         bus.resp_rdata <= '0;
      end else begin
         // DM commands and the completion pulse last exactly one cycle.
         DM_enable      <= 1'b0;
         DM_read        <= 1'b0;
         DM_write       <= 1'b0;
         bus.resp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  wr_l       <= bus.req_write;
                  size_l     <= bus.req_size;
                  uns_l      <= bus.req_unsigned;
                  lane_l     <= bus.req_addr[1:0];
                  wdata_l    <= bus.req_wdata;
                  DM_address <= bus.req_addr[address_size+1:2];
                  if (req_err) begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= 1'b1;
                     bus.resp_rdata <= '0;
                  end else if (bus.req_write && (bus.req_size == 2'b10)) begin
                     state     <= WR;
                     DM_enable <= 1'b1;
                     DM_write  <= 1'b1;
                  end else begin
                     state     <= RD;
                     DM_enable <= 1'b1;
                     DM_read   <= 1'b1;
                  end
               end
            end
            RD: state <= CAP;
            CAP: begin
               word_q <= DM_out;
               if (wr_l) begin
                  state     <= WR;
                  DM_enable <= 1'b1;
                  DM_write  <= 1'b1;
               end else begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= 1'b0;
                  bus.resp_rdata <= extract(DM_out, size_l, uns_l, lane_l);
               end
            end
            WR: begin
               state          <= RESP;
               bus.resp_valid <= 1'b1;
               bus.resp_err   <= 1'b0;
               bus.resp_rdata <= '0;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl: the driver queues expected DM commands and
// responses per request; negedge monitors pop and compare them, including latency.
module tb_dm_access_ctrl;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          acc;
   } resp_t;

   typedef struct {
      logic        wr;
      logic [14:0] addr;
      logic [31:0] data;
      int          lat;
      int          acc;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        DM_enable, DM_read, DM_write;
   logic [14:0] DM_address;
   logic [31:0] DM_in;
   logic [31:0] DM_out = 32'h0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   resp_t       resp_q[$];
   cmd_t        cmd_q[$];
   logic [31:0] mem[logic [14:0]];
   logic        last_err = 1'b0;
   logic [31:0] last_rdata = 32'h0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dm_access_ctrl_if #(.data_size(32), .address_size(15)) bus ();

   dm_access_ctrl #(.data_size(32), .address_size(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .DM_enable (DM_enable),
      .DM_read   (DM_read),
      .DM_write  (DM_write),
      .DM_address(DM_address),
      .DM_in     (DM_in),
      .DM_out    (DM_out)
   );

   // Word-wide data memory with one-cycle read latency.
   always @(posedge clk) begin
      if (DM_enable && DM_read) DM_out <= mem.exists(DM_address) ? mem[DM_address] : 32'h0;
      if (DM_enable && DM_write) mem[DM_address] = DM_in;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [16:0] a, input logic [31:0] d, input logic hold,
                        input logic want_resp, input logic e_err, input logic [31:0] e_rdata,
                        input int rd_lat, input int wr_lat, input logic [31:0] e_wdata,
                        input int e_lat, output int acc);
      int n;
      bus.req_write    = w;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = a;
      bus.req_wdata    = d;
      bus.req_valid    = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: req_ready stayed 0 for 50 cycles, required 1");
         bus.req_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc;
      if (rd_lat > 0) cmd_q.push_back('{1'b0, a[16:2], 32'h0, rd_lat, acc});
      if (wr_lat > 0) cmd_q.push_back('{1'b1, a[16:2], e_wdata, wr_lat, acc});
      if (want_resp) resp_q.push_back('{e_err, e_rdata, e_lat, acc});
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
   endtask

   // Response monitor; between responses the last values must be held.
   always @(negedge clk) begin
      if (rst) begin
         last_err   = 1'b0;
         last_rdata = 32'h0;
      end else if (bus.resp_valid) begin
         if (resp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding, required 0");
         end else begin
            resp_t r;
            r = resp_q.pop_front();
            check("resp_err", 32'(bus.resp_err), 32'(r.err));
            check("resp_rdata", bus.resp_rdata, r.rdata);
            check("resp_latency", 32'(cyc - r.acc), 32'(r.lat));
            last_err   = r.err;
            last_rdata = r.rdata;
         end
      end else begin
         check("resp_hold_err", 32'(bus.resp_err), 32'(last_err));
         check("resp_hold_rdata", bus.resp_rdata, last_rdata);
      end
   end

   // DM command monitor.
   always @(negedge clk) begin
      if (!rst) begin
         if (DM_enable) begin
            if (cmd_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_dm_cmd: DM_enable=1 rd=%0b wr=%0b addr=0x%0h, required 0",
                        DM_read, DM_write, DM_address);
            end else begin
               cmd_t c;
               c = cmd_q.pop_front();
               check("dm_rd_wr", 32'({DM_read, DM_write}), c.wr ? 32'h1 : 32'h2);
               check("dm_address", 32'(DM_address), 32'(c.addr));
               if (c.wr) check("dm_in", DM_in, c.data);
               check("dm_latency", 32'(cyc - c.acc), 32'(c.lat));
            end
         end else begin
            check("dm_idle_cmd", 32'({DM_read, DM_write}), 32'h0);
         end
         if (!DM_write) check("dm_in_idle", DM_in, 32'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, acc1, acc2;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;

      repeat (3) @(negedge clk);
      check("rst_ctrl", 32'({bus.req_ready, bus.resp_valid, bus.resp_err,
                             DM_enable, DM_read, DM_write}), 32'h0);
      check("rst_rdata", bus.resp_rdata, 32'h0);
      check("rst_addr", 32'(DM_address), 32'h0);
      check("rst_dm_in", DM_in, 32'h0);
      rst = 1'b0;
      #1 check("ready_after_rst", 32'(bus.req_ready), 32'h1);
      @(negedge clk);

      // w sz uns addr wdata hold resp err rdata rd wr wdata_exp lat
      issue(1, 2'b10, 0, 17'h10, 32'hdeadbeef, 0, 1, 0, 32'h0,        0, 1, 32'hdeadbeef, 2, acc);
      issue(0, 2'b00, 0, 17'h13, 32'h0,        0, 1, 0, 32'hffffffde, 1, 0, 32'h0,        3, acc);
      issue(0, 2'b00, 1, 17'h13, 32'h0,        0, 1, 0, 32'h000000de, 1, 0, 32'h0,        3, acc);
      issue(1, 2'b01, 0, 17'h12, 32'h1234,     0, 1, 0, 32'h0,        1, 3, 32'h1234beef, 4, acc);
      issue(0, 2'b10, 0, 17'h10, 32'h0,        0, 1, 0, 32'h1234beef, 1, 0, 32'h0,        3, acc);
      issue(0, 2'b01, 0, 17'h10, 32'h0,        0, 1, 0, 32'hffffbeef, 1, 0, 32'h0,        3, acc);
      issue(0, 2'b01, 1, 17'h12, 32'h0,        0, 1, 0, 32'h00001234, 1, 0, 32'h0,        3, acc);
      issue(1, 2'b00, 0, 17'h11, 32'hffffffa5, 0, 1, 0, 32'h0,        1, 3, 32'h1234a5ef, 4, acc);
      issue(0, 2'b00, 0, 17'h11, 32'h0,        0, 1, 0, 32'hffffffa5, 1, 0, 32'h0,        3, acc);
      issue(0, 2'b10, 0, 17'h10, 32'h0,        0, 1, 0, 32'h1234a5ef, 1, 0, 32'h0,        3, acc);
      // Misaligned and illegal-size requests complete with an error and no DM traffic.
      issue(0, 2'b10, 0, 17'h11, 32'h0,        0, 1, 1, 32'h0,        0, 0, 32'h0,        1, acc);
      issue(0, 2'b00, 1, 17'h12, 32'h0,        0, 1, 0, 32'h00000034, 1, 0, 32'h0,        3, acc);
      issue(1, 2'b01, 0, 17'h13, 32'h5555,     0, 1, 1, 32'h0,        0, 0, 32'h0,        1, acc);
      issue(0, 2'b11, 0, 17'h10, 32'h0,        0, 1, 1, 32'h0,        0, 0, 32'h0,        1, acc);
      issue(1, 2'b10, 0, 17'h12, 32'h99999999, 0, 1, 1, 32'h0,        0, 0, 32'h0,        1, acc);

      // Reset while in CAP of a byte store: only the read may appear.
      issue(1, 2'b00, 0, 17'h10, 32'h77,       0, 0, 0, 32'h0,        1, 0, 32'h0,        0, acc);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_ctrl", 32'({bus.req_ready, bus.resp_valid, DM_enable, DM_write}), 32'h0);
      check("abort_dm_in", DM_in, 32'h0);
      rst = 1'b0;
      #1 check("abort_ready", 32'(bus.req_ready), 32'h1);
      issue(0, 2'b10, 0, 17'h10, 32'h0,        0, 1, 0, 32'h1234a5ef, 1, 0, 32'h0,        3, acc);

      // Two word stores with req_valid held: the second waits for IDLE.
      issue(1, 2'b10, 0, 17'h20, 32'h11111111, 1, 1, 0, 32'h0,        0, 1, 32'h11111111, 2, acc1);
      issue(1, 2'b10, 0, 17'h24, 32'h22222222, 0, 1, 0, 32'h0,        0, 1, 32'h22222222, 2, acc2);
      check("held_accept_gap", 32'(acc2 - acc1), 32'h3);
      issue(0, 2'b10, 0, 17'h24, 32'h0,        0, 1, 0, 32'h22222222, 1, 0, 32'h0,        3, acc);
      issue(0, 2'b10, 0, 17'h20, 32'h0,        0, 1, 0, 32'h11111111, 1, 0, 32'h0,        3, acc);

      repeat (10) @(negedge clk);
      check("resp_queue_drained", 32'(resp_q.size()), 32'h0);
      check("cmd_queue_drained", 32'(cmd_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
